par_bus_wr: RTL and testbench

- Writer end of the parameter bus (addr / pw_par / en) consumed by the level-register / PWM blocks such as the OCD level generator.
- Parses a byte stream from the upstream UART receiver into framed parameter writes.
- Validates each frame and issues a single-cycle write strobe.
- Sits between the serial receiver and all bus-addressed parameter registers.

---
 rtl/par_bus_pkg.sv | 14 +
 rtl/frame_timer.sv | 42 ++++
 rtl/par_bus_wr.sv | 137 +++++++++++++
 tb/tb_par_bus_wr.sv | 325 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/par_bus_pkg.sv
// Shared definitions for the parameter-bus writer: frame parser states and framing constants.
package par_bus_pkg;

    typedef enum logic [1:0] {
        IDLE,
        GET_A,
        GET_D,
        GET_C
    } state_t;

    localparam logic [7:0] HDR_DEFAULT = 8'hA5;
    localparam int         FRAME_LEN   = 4;

endpackage

// File: rtl/frame_timer.sv
// Inter-byte gap timer: reloads on clear, counts down while enabled, pulses expire for one
// cycle when LIMIT enabled cycles pass without a clear.
module frame_timer #(
    parameter int LIMIT = 10000
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    input  logic enable,
    output logic expire
);

    localparam int            CW     = (LIMIT > 1) ? $clog2(LIMIT) : 1;
    localparam logic [CW-1:0] RELOAD = CW'(LIMIT - 1);

    logic [CW-1:0] cnt_q, cnt_d;

    // A clear in the limit cycle takes priority, so a late byte is never timed out.
    always_comb begin
        cnt_d  = cnt_q;
        expire = 1'b0;
        if (clear) begin
            cnt_d = RELOAD;
        end else if (enable) begin
            if (cnt_q == '0) begin
                expire = 1'b1;
                cnt_d  = RELOAD;
            end else begin
                cnt_d = cnt_q - 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/par_bus_wr.sv
// Parameter-bus writer: parses HDR,A,D,C byte frames from the UART receiver and issues a
// one-cycle write strobe for valid frames, or a frame_err pulse for rejected/timed-out ones.
module par_bus_wr
    import par_bus_pkg::*;
#(
    parameter int         CLK_MHZ     = 100,
    parameter int         PAR_MAX_VAL = 255,
    parameter int         ADDR_MAX    = 4,
    parameter int         TIMEOUT_US  = 100,
    parameter logic [7:0] HDR         = HDR_DEFAULT,
    localparam int        PW          = $clog2(PAR_MAX_VAL + 1),
    localparam int        AW          = $clog2(ADDR_MAX + 1)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [7:0]    rx_data,
    input  logic          rx_valid,
    output logic [PW-1:0] pw_par,
    output logic [AW-1:0] addr,
    output logic          en,
    output logic          frame_err,
    output logic [7:0]    err_cnt,
    output logic          busy
);

    localparam logic [7:0] ADDR_MAX_B = 8'(ADDR_MAX);
    localparam logic [7:0] PAR_MAX_B  = 8'(PAR_MAX_VAL);

    state_t        state_q, state_d;
    logic [7:0]    a_q, a_d;
    logic [7:0]    d_q, d_d;
    logic [PW-1:0] pw_par_q, pw_par_d;
    logic [AW-1:0] addr_q, addr_d;
    logic          en_q, en_d;
    logic          frame_err_q, frame_err_d;
    logic [7:0]    err_cnt_q, err_cnt_d;
    logic [7:0]    sum;
    logic          reject;
    logic          timeout_expire;

    assign busy = (state_q != IDLE);

    frame_timer #(
        .LIMIT (CLK_MHZ * TIMEOUT_US)
    ) u_frame_timer (
        .clk    (clk),
        .rst    (rst),
        .clear  (rx_valid),
        .enable (busy),
        .expire (timeout_expire)
    );

    // Range check uses the full 8-bit A; truncation to the bus width happens only on write.
    always_comb begin
        state_d     = state_q;
        a_d         = a_q;
        d_d         = d_q;
        pw_par_d    = pw_par_q;
        addr_d      = addr_q;
        en_d        = 1'b0;
        frame_err_d = 1'b0;
        err_cnt_d   = err_cnt_q;
        reject      = 1'b0;
        sum         = a_q + d_q;

        case (state_q)
            IDLE: begin
                if (rx_valid && rx_data == HDR) state_d = GET_A;
            end
            GET_A: begin
                if (rx_valid) begin
                    a_d     = rx_data;
                    state_d = GET_D;
                end
            end
            GET_D: begin
                if (rx_valid) begin
                    d_d     = rx_data;
                    state_d = GET_C;
                end
            end
            GET_C: begin
                if (rx_valid) begin
                    state_d = IDLE;
                    if (rx_data == sum && a_q <= ADDR_MAX_B) begin
                        en_d     = 1'b1;
                        addr_d   = a_q[AW-1:0];
                        pw_par_d = (d_q > PAR_MAX_B) ? PAR_MAX_B[PW-1:0] : d_q[PW-1:0];
                    end else begin
                        reject = 1'b1;
                    end
                end
            end
            default: state_d = IDLE;
        endcase

        // Expiry is only possible in a non-IDLE cycle without rx_valid.
        if (timeout_expire) begin
            state_d = IDLE;
            reject  = 1'b1;
        end

        if (reject) begin
            frame_err_d = 1'b1;
            if (err_cnt_q != 8'hFF) err_cnt_d = err_cnt_q + 8'd1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            a_q         <= '0;
            d_q         <= '0;
            pw_par_q    <= '0;
            addr_q      <= '0;
            en_q        <= 1'b0;
            frame_err_q <= 1'b0;
            err_cnt_q   <= '0;
        end else begin
            state_q     <= state_d;
            a_q         <= a_d;
            d_q         <= d_d;
            pw_par_q    <= pw_par_d;
            addr_q      <= addr_d;
            en_q        <= en_d;
            frame_err_q <= frame_err_d;
            err_cnt_q   <= err_cnt_d;
        end
    end

    assign pw_par    = pw_par_q;
    assign addr      = addr_q;
    assign en        = en_q;
    assign frame_err = frame_err_q;
    assign err_cnt   = err_cnt_q;

endmodule

// File: tb/tb_par_bus_wr.sv
// Self-checking bench for par_bus_wr: vector table, directed corner sequences and random
// frames checked against a frame-level reference model with an expected-event queue.
module tb_par_bus_wr;

    localparam int L    = 100 * 100;
    localparam int PMAX = 200;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [7:0] rx_data = 8'h00;
    logic       rx_valid = 1'b0;
    logic [7:0] pw_par;
    logic [2:0] addr;
    logic       en, frame_err, busy;
    logic [7:0] err_cnt;

    par_bus_wr #(
        .CLK_MHZ     (100),
        .PAR_MAX_VAL (PMAX),
        .ADDR_MAX    (4),
        .TIMEOUT_US  (100),
        .HDR         (8'hA5)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .rx_data   (rx_data),
        .rx_valid  (rx_valid),
        .pw_par    (pw_par),
        .addr      (addr),
        .en        (en),
        .frame_err (frame_err),
        .err_cnt   (err_cnt),
        .busy      (busy)
    );

    // ---------------- clock / cycle counter ----------------
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int checks   = 0;
    int failures = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // ---------------- reference model ----------------
    typedef struct packed {
        logic        is_wr;
        logic [2:0]  addr;
        logic [7:0]  par;
        logic [7:0]  errc;
        logic [31:0] cyc;
    } ev_t;

    ev_t        exp_q[$];
    logic [7:0] frm[$];
    int         gap = 0;
    logic [2:0] mdl_addr = 3'd0;
    logic [7:0] mdl_par = 8'd0;
    int         mdl_err = 0;

    task automatic push_ev(input logic w);
        ev_t e;
        e.is_wr = w;
        e.addr  = mdl_addr;
        e.par   = mdl_par;
        e.errc  = 8'(mdl_err);
        e.cyc   = 32'(cyc);
        exp_q.push_back(e);
    endtask

    task automatic mdl_reject();
        if (mdl_err < 255) mdl_err++;
        push_ev(1'b0);
    endtask

    task automatic mdl_byte(input logic [7:0] b);
        gap = 0;
        if (frm.size() == 0) begin
            if (b == 8'hA5) frm.push_back(b);
        end else begin
            frm.push_back(b);
            if (frm.size() == 4) begin
                int s;
                s = (int'(frm[1]) + int'(frm[2])) % 256;
                if (s == int'(frm[3]) && int'(frm[1]) <= 4) begin
                    mdl_addr = frm[1][2:0];
                    mdl_par  = (int'(frm[2]) > PMAX) ? 8'(PMAX) : frm[2];
                    push_ev(1'b1);
                end else begin
                    mdl_reject();
                end
                frm.delete();
            end
        end
    endtask

    task automatic mdl_idle();
        gap++;
        if (frm.size() != 0 && gap == L) begin
            frm.delete();
            mdl_reject();
        end
    endtask

    task automatic mdl_reset();
        frm.delete();
        exp_q.delete();
        gap      = 0;
        mdl_addr = 3'd0;
        mdl_par  = 8'd0;
        mdl_err  = 0;
    endtask

    // ---------------- scoreboard monitor ----------------
    always @(negedge clk) begin : monitor
        ev_t ev;
        if (!rst) begin
            while (exp_q.size() != 0 && int'(exp_q[0].cyc) < cyc) begin
                ev = exp_q.pop_front();
                check("missed_event_cycle", 32'(cyc), ev.cyc);
            end
            if (en || frame_err) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_event", 32'({en, frame_err}), 32'd0);
                end else begin
                    ev = exp_q.pop_front();
                    check("ev_cycle", 32'(cyc), ev.cyc);
                    check("ev_kind", 32'({en, frame_err}), 32'(ev.is_wr ? 2'b10 : 2'b01));
                    check("ev_addr", 32'(addr), 32'(ev.addr));
                    check("ev_pw_par", 32'(pw_par), 32'(ev.par));
                    check("ev_err_cnt", 32'(err_cnt), 32'(ev.errc));
                end
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic apply_cycle(input logic v, input logic [7:0] d);
        rx_valid = v;
        rx_data  = d;
        @(posedge clk);
        #1;
        rx_valid = 1'b0;
        if (v) mdl_byte(d);
        else   mdl_idle();
    endtask

    task automatic send(input logic [7:0] b);
        apply_cycle(1'b1, b);
    endtask

    task automatic idle(input int n);
        repeat (n) apply_cycle(1'b0, 8'h00);
    endtask

    task automatic send_frame(input logic [7:0] a, input logic [7:0] d, input logic [7:0] c);
        send(8'hA5);
        send(a);
        send(d);
        send(c);
    endtask

    // ---------------- vector table ----------------
    typedef struct {
        logic       v;
        logic [7:0] d;
        logic       en;
        logic       fe;
        logic       busy;
    } row_t;

    row_t tbl[$];

    task automatic add(input logic v, input logic [7:0] d, input logic e, input logic fe,
                       input logic b);
        row_t r;
        r.v = v; r.d = d; r.en = e; r.fe = fe; r.busy = b;
        tbl.push_back(r);
    endtask

    task automatic add_gap3(input logic b);
        repeat (3) add(1'b0, 8'h00, 1'b0, 1'b0, b);
    endtask

    // ---------------- test sequence ----------------
    initial begin
        logic [7:0] a, d, c;
        int         mode;

        #2;
        check("reset_en", 32'(en), 32'd0);
        check("reset_frame_err", 32'(frame_err), 32'd0);
        check("reset_busy", 32'(busy), 32'd0);
        check("reset_addr", 32'(addr), 32'd0);
        check("reset_pw_par", 32'(pw_par), 32'd0);
        check("reset_err_cnt", 32'(err_cnt), 32'd0);
        @(posedge clk);
        @(posedge clk);
        #1;
        rst = 1'b0;
        mdl_reset();

        // Valid write A5,02,80,82 with 3 idle cycles between bytes
        add(1, 8'hA5, 0, 0, 1); add_gap3(1);
        add(1, 8'h02, 0, 0, 1); add_gap3(1);
        add(1, 8'h80, 0, 0, 1); add_gap3(1);
        add(1, 8'h82, 1, 0, 0); add(0, 8'h00, 0, 0, 0);
        // Noise in IDLE is ignored
        add(1, 8'h33, 0, 0, 0); add(1, 8'h82, 0, 0, 0);
        // Bad checksum
        add(1, 8'hA5, 0, 0, 1); add(1, 8'h01, 0, 0, 1); add(1, 8'h10, 0, 0, 1);
        add(1, 8'h00, 0, 1, 0); add(0, 8'h00, 0, 0, 0);
        // Address out of range, checksum correct
        add(1, 8'hA5, 0, 0, 1); add(1, 8'h05, 0, 0, 1); add(1, 8'h10, 0, 0, 1);
        add(1, 8'h15, 0, 1, 0); add(0, 8'h00, 0, 0, 0);
        // Back-to-back valid frames, HDR as data in the second frame
        add(1, 8'hA5, 0, 0, 1); add(1, 8'h01, 0, 0, 1); add(1, 8'hA5, 0, 0, 1);
        add(1, 8'hA6, 1, 0, 0);
        add(1, 8'hA5, 0, 0, 1); add(1, 8'h04, 0, 0, 1); add(1, 8'hC8, 0, 0, 1);
        add(1, 8'hCC, 1, 0, 0); add(0, 8'h00, 0, 0, 0);

        for (int i = 0; i < tbl.size(); i++) begin
            apply_cycle(tbl[i].v, tbl[i].d);
            check($sformatf("tbl_row_%0d_en_fe_busy", i), 32'({en, frame_err, busy}),
                  32'({tbl[i].en, tbl[i].fe, tbl[i].busy}));
        end
        check("tbl_addr", 32'(addr), 32'd4);
        check("tbl_pw_par", 32'(pw_par), 32'd200);
        check("tbl_err_cnt", 32'(err_cnt), 32'd2);

        // Timeout after A5,03
        send(8'hA5);
        send(8'h03);
        idle(L - 1);
        check("timeout_before_busy_fe", 32'({busy, frame_err}), 32'b10);
        idle(1);
        check("timeout_at_limit_busy_fe", 32'({busy, frame_err}), 32'b01);
        check("timeout_err_cnt", 32'(err_cnt), 32'd3);
        send_frame(8'h03, 8'h07, 8'h0A);
        check("after_timeout_en", 32'(en), 32'd1);
        check("after_timeout_addr", 32'(addr), 32'd3);
        check("after_timeout_pw_par", 32'(pw_par), 32'd7);

        // Byte arriving in the limit cycle wins
        send(8'hA5);
        idle(L - 1);
        send(8'h01);
        check("limit_byte_busy_fe", 32'({busy, frame_err}), 32'b10);
        send(8'h02);
        send(8'h03);
        check("limit_frame_en", 32'(en), 32'd1);
        check("limit_frame_addr_par", 32'({addr, pw_par}), 32'({3'd1, 8'd2}));
        check("limit_err_cnt", 32'(err_cnt), 32'd3);

        // Clamp at PAR_MAX_VAL = 200
        send_frame(8'h00, 8'hFF, 8'hFF);
        check("clamp_en", 32'(en), 32'd1);
        check("clamp_pw_par", 32'(pw_par), 32'd200);
        check("clamp_addr", 32'(addr), 32'd0);

        // Random frames and noise against the model
        for (int n = 0; n < 150; n++) begin
            mode = int'($urandom_range(0, 4));
            a = 8'($urandom_range(0, 4));
            d = 8'($urandom_range(0, 255));
            c = a + d;
            if (mode == 2) c = c + 8'($urandom_range(1, 255));
            if (mode == 3) begin
                a = 8'($urandom_range(5, 255));
                c = a + d;
            end
            if (mode == 4) begin
                send(8'($urandom_range(0, 255)));
            end else begin
                send(8'hA5);
                idle(int'($urandom_range(0, 2)));
                send(a);
                idle(int'($urandom_range(0, 2)));
                send(d);
                idle(int'($urandom_range(0, 2)));
                send(c);
            end
            idle(int'($urandom_range(0, 2)));
        end
        idle(3);
        check("random_err_cnt", 32'(err_cnt), 32'(mdl_err));
        check("random_addr_par", 32'({addr, pw_par}), 32'({mdl_addr, mdl_par}));

        // Reset mid-frame
        send(8'hA5);
        send(8'h01);
        rst = 1'b1;
        #2;
        check("midreset_async_outputs", 32'({en, frame_err, busy, addr, pw_par, err_cnt}), 32'd0);
        @(posedge clk);
        #1;
        check("midreset_held_outputs", 32'({en, frame_err, busy, addr, pw_par, err_cnt}), 32'd0);
        rst = 1'b0;
        mdl_reset();
        send_frame(8'h02, 8'h05, 8'h07);
        check("post_reset_en", 32'(en), 32'd1);
        check("post_reset_addr_par", 32'({addr, pw_par}), 32'({3'd2, 8'd5}));

        // Saturation: 300 rejected frames
        for (int n = 0; n < 300; n++) send_frame(8'h00, 8'h00, 8'h01);
        idle(1);
        check("sat_err_cnt", 32'(err_cnt), 32'd255);
        check("sat_addr_par_kept", 32'({addr, pw_par}), 32'({3'd2, 8'd5}));

        idle(5);
        check("exp_queue_drained", 32'(exp_q.size()), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
